// File: rtl/qar_dac_pkg.sv
// Shared constants and types for the queued four-channel DAC output block:
// register offsets, DATA/CTRL/STATUS field positions and the FSM state type.
package qar_dac_pkg;

   // Word index taken from bus_addr[3:2]
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_CTRL   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_DIV    = 2'd3;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_FLUSH  = 1;
   localparam int CTRL_IRQ_EN = 2;

   localparam int DATA_CH_LSB   = 16;
   localparam int DATA_CH_MSB   = 17;
   localparam int DATA_CODE_LSB = 0;
   localparam int DATA_CODE_MSB = 11;

   localparam int ST_FULL  = 8;
   localparam int ST_EMPTY = 9;
   localparam int ST_OVF   = 10;
   localparam int ST_UND   = 11;

   localparam logic [15:0] DIV_RST = 16'h00FF;

   typedef enum logic {
      ST_DISABLED = 1'b0,
      ST_RUN      = 1'b1
   } qar_state_e;

   typedef struct packed {
      logic [1:0]  ch;
      logic [11:0] code;
   } sample_t;

   function automatic sample_t to_sample(input logic [31:0] w);
      sample_t s;
      s.ch   = w[DATA_CH_MSB:DATA_CH_LSB];
      s.code = w[DATA_CODE_MSB:DATA_CODE_LSB];
      return s;
   endfunction

endpackage

// File: rtl/qar_dac_fifo.sv
// Sample queue: power-of-two depth, wrapping pointers, level 0..DEPTH.
// A push while full is taken only when a pop frees the head slot in the same cycle.
module qar_dac_fifo
   import qar_dac_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  sample_t                wdata,
   output sample_t                rdata,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   sample_t         mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && (!full || do_pop) && !flush;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset: level/pointers decide what is valid
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/qar_dac_out.sv
// Bus-fed four-channel DAC output sequencer: samples are queued and released
// one per divider tick onto held 12-bit channel outputs.
module qar_dac_out
   import qar_dac_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_WIDTH  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bus_valid,
   input  logic        bus_we,
   input  logic [3:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic        bus_ready,
   output logic [31:0] bus_rdata,
   output logic [11:0] dac_ch0,
   output logic [11:0] dac_ch1,
   output logic [11:0] dac_ch2,
   output logic [11:0] dac_ch3,
   output logic        dac_update,
   output logic [1:0]  dac_chan,
   output logic        dac_irq
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   qar_state_e           state;
   logic [DIV_WIDTH-1:0] cnt;
   logic [DIV_WIDTH-1:0] div_reg;
   logic                 irq_en;
   logic                 ovf;
   logic                 und;
   logic [11:0]          dac_q [4];

   logic [1:0]           reg_sel;
   logic                 wr;
   logic                 push;
   logic                 ctrl_wr;
   logic                 status_wr;
   logic                 div_wr;
   logic                 flush;
   logic                 tick;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [LW-1:0]        level;
   sample_t              head;
   logic                 unused_bits;

   assign bus_ready = bus_valid;
   assign reg_sel   = bus_addr[3:2];
   assign wr        = bus_valid && bus_we;
   assign push      = wr && (reg_sel == REG_DATA);
   assign ctrl_wr   = wr && (reg_sel == REG_CTRL);
   assign status_wr = wr && (reg_sel == REG_STATUS);
   assign div_wr    = wr && (reg_sel == REG_DIV);
   assign flush     = ctrl_wr && bus_wdata[CTRL_FLUSH];
   assign tick      = (state == ST_RUN) && (cnt == '0);
   // A flush landing on a tick suppresses that tick's pop
   assign pop       = tick && !fifo_empty && !flush;

   assign unused_bits = &{1'b0, bus_addr[1:0], bus_wdata};

   qar_dac_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (to_sample(bus_wdata)),
      .rdata (head),
      .level (level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_DISABLED;
         cnt        <= '0;
         div_reg    <= DIV_WIDTH'(DIV_RST);
         irq_en     <= 1'b0;
         ovf        <= 1'b0;
         und        <= 1'b0;
         dac_update <= 1'b0;
         dac_chan   <= 2'd0;
         for (int i = 0; i < 4; i++) dac_q[i] <= 12'h000;
      end else begin
         dac_update <= 1'b0;
         case (state)
            ST_DISABLED: begin
               if (ctrl_wr && bus_wdata[CTRL_EN]) begin
                  state <= ST_RUN;
                  cnt   <= div_reg;
               end
            end
            ST_RUN: begin
               cnt <= (cnt == '0) ? div_reg : cnt - DIV_WIDTH'(1);
               if (ctrl_wr && !bus_wdata[CTRL_EN]) state <= ST_DISABLED;
               if (pop) begin
                  dac_q[head.ch] <= head.code;
                  dac_update     <= 1'b1;
                  dac_chan       <= head.ch;
               end
            end
            default: state <= ST_DISABLED;
         endcase
         if (ctrl_wr) irq_en  <= bus_wdata[CTRL_IRQ_EN];
         if (div_wr)  div_reg <= bus_wdata[DIV_WIDTH-1:0];
         // Sticky bits: a new event in the clearing cycle wins over the clear
         ovf <= (ovf && !(status_wr && bus_wdata[ST_OVF])) ||
                (push && fifo_full && !pop);
         und <= (und && !(status_wr && bus_wdata[ST_UND])) ||
                (tick && fifo_empty);
      end
   end

   always_comb begin
      bus_rdata = '0;
      case (reg_sel)
         REG_CTRL: begin
            bus_rdata[CTRL_EN]     = (state == ST_RUN);
            bus_rdata[CTRL_IRQ_EN] = irq_en;
         end
         REG_STATUS: begin
            bus_rdata[LW-1:0]  = level;
            bus_rdata[ST_FULL]  = fifo_full;
            bus_rdata[ST_EMPTY] = fifo_empty;
            bus_rdata[ST_OVF]   = ovf;
            bus_rdata[ST_UND]   = und;
         end
         REG_DIV:  bus_rdata[DIV_WIDTH-1:0] = div_reg;
         default:  bus_rdata = '0;
      endcase
   end

   assign dac_ch0 = dac_q[0];
   assign dac_ch1 = dac_q[1];
   assign dac_ch2 = dac_q[2];
   assign dac_ch3 = dac_q[3];
   assign dac_irq = (state == ST_RUN) && irq_en && (level <= LW'(FIFO_DEPTH / 2));

endmodule

// File: tb/tb_qar_dac_out.sv
// Directed plus randomized bench for qar_dac_out against a queue-based
// reference that tracks tick times as absolute cycle numbers.
module tb_qar_dac_out;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bus_valid = 1'b0;
   logic        bus_we = 1'b0;
   logic [3:0]  bus_addr = 4'h0;
   logic [31:0] bus_wdata = 32'h0;
   logic        bus_ready;
   logic [31:0] bus_rdata;
   logic [11:0] dac_ch0, dac_ch1, dac_ch2, dac_ch3;
   logic        dac_update;
   logic [1:0]  dac_chan;
   logic        dac_irq;

   always #5 clk = ~clk;

   qar_dac_out #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus_valid  (bus_valid),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_ready  (bus_ready),
      .bus_rdata  (bus_rdata),
      .dac_ch0    (dac_ch0),
      .dac_ch1    (dac_ch1),
      .dac_ch2    (dac_ch2),
      .dac_ch3    (dac_ch3),
      .dac_update (dac_update),
      .dac_chan   (dac_chan),
      .dac_irq    (dac_irq)
   );

   // Reference model state
   logic [13:0] q [$];
   bit          m_en, m_irq_en, m_ovf, m_und, m_upd;
   int          m_div;
   int          edge_n, next_tick;
   logic [11:0] m_dac [4];
   logic [1:0]  m_chan;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_en = 0; m_irq_en = 0; m_ovf = 0; m_und = 0; m_upd = 0;
      m_div = 255; next_tick = 0; m_chan = 2'd0;
      for (int i = 0; i < 4; i++) m_dac[i] = 12'h000;
   endtask

   function automatic logic [31:0] m_read(input logic [3:0] a);
      logic [31:0] r;
      r = '0;
      case (a[3:2])
         2'd1: begin r[0] = m_en; r[2] = m_irq_en; end
         2'd2: begin
            r[4:0] = 5'(q.size());
            r[8]   = (q.size() == DEPTH);
            r[9]   = (q.size() == 0);
            r[10]  = m_ovf;
            r[11]  = m_und;
         end
         2'd3: r[15:0] = 16'(m_div);
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic model_edge(input logic v, input logic we, input logic [3:0] a, input logic [31:0] d);
      bit wr, tick, flush, pop, was_empty;
      logic [13:0] s;
      wr = v && we;
      edge_n++;
      tick = m_en && (edge_n == next_tick);
      flush = wr && (a[3:2] == 2'd1) && d[1];
      was_empty = (q.size() == 0);
      pop = tick && !was_empty && !flush;
      m_upd = pop;
      if (pop) begin
         s = q.pop_front();
         m_dac[s[13:12]] = s[11:0];
         m_chan = s[13:12];
      end
      if (tick) next_tick = edge_n + m_div + 1;
      if (wr) begin
         case (a[3:2])
            2'd0: if (q.size() < DEPTH) q.push_back({d[17:16], d[11:0]}); else m_ovf = 1;
            2'd1: begin
               if (flush) q.delete();
               if (!m_en && d[0]) next_tick = edge_n + m_div + 1;
               m_en = d[0];
               m_irq_en = d[2];
            end
            2'd2: begin
               if (d[10]) m_ovf = 0;
               if (d[11]) m_und = 0;
            end
            default: m_div = int'(d[15:0]);
         endcase
      end
      if (tick && was_empty) m_und = 1;
   endtask

   task automatic check_outs();
      chk("dac_ch0", dac_ch0, m_dac[0]);
      chk("dac_ch1", dac_ch1, m_dac[1]);
      chk("dac_ch2", dac_ch2, m_dac[2]);
      chk("dac_ch3", dac_ch3, m_dac[3]);
      chk("dac_update", dac_update, m_upd);
      if (m_upd) chk("dac_chan", dac_chan, m_chan);
      chk("dac_irq", dac_irq, m_en && m_irq_en && (q.size() <= DEPTH / 2));
   endtask

   task automatic step(input logic v, input logic we, input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      bus_valid = v; bus_we = we; bus_addr = a; bus_wdata = d;
      #1;
      chk("bus_ready", bus_ready, v);
      if (v && !we) chk("bus_rdata", bus_rdata, m_read(a));
      @(posedge clk);
      model_edge(v, we, a, d);
      #1;
      check_outs();
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      step(1'b1, 1'b1, a, d);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 4'h0, 32'h0);
   endtask

   // Read with an extra check against a fixed expected value under a mask
   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] mask,
                         input logic [31:0] exp);
      @(negedge clk);
      bus_valid = 1'b1; bus_we = 1'b0; bus_addr = a; bus_wdata = 32'h0;
      #1;
      chk(tag, bus_rdata & mask, exp);
      chk("bus_rdata", bus_rdata, m_read(a));
      @(posedge clk);
      model_edge(1'b1, 1'b0, a, 32'h0);
      #1;
      check_outs();
   endtask

   task automatic wait_tick_next();
      for (int i = 0; i < 80 && (edge_n + 1 != next_tick); i++) idle();
      chk("tick_reached", (edge_n + 1 == next_tick), 1'b1);
   endtask

   initial begin
      int pulse_edge [$];
      int r;
      logic [31:0] d;
      model_reset();
      edge_n = 0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ch0", dac_ch0, 12'h000);
      chk("rst_ch3", dac_ch3, 12'h000);
      chk("rst_update", dac_update, 1'b0);
      chk("rst_chan", dac_chan, 2'd0);
      chk("rst_irq", dac_irq, 1'b0);
      rst_n = 1'b1;
      rd_chk("rst_div", 4'hC, 32'hFFFF_FFFF, 32'h0000_00FF);
      rd_chk("rst_status", 4'h8, 32'hFFFF_FFFF, 32'h0000_0200);

      // Three samples released on ticks 4 cycles apart
      wr(4'hC, 32'd3);
      wr(4'h0, 32'h0000_0145);
      wr(4'h0, 32'h0001_02A7);
      wr(4'h0, 32'h0002_03E1);
      wr(4'h4, 32'h1);
      for (int i = 0; i < 14; i++) begin
         idle();
         if (dac_update === 1'b1) pulse_edge.push_back(edge_n);
      end
      chk("seq_pulses", pulse_edge.size(), 3);
      if (pulse_edge.size() == 3) begin
         chk("seq_gap1", pulse_edge[1] - pulse_edge[0], 4);
         chk("seq_gap2", pulse_edge[2] - pulse_edge[1], 4);
      end
      chk("seq_ch0", dac_ch0, 12'h145);
      chk("seq_ch1", dac_ch1, 12'h2A7);
      chk("seq_ch2", dac_ch2, 12'h3E1);
      chk("seq_ch3", dac_ch3, 12'h000);

      // Overflow while disabled, then clear it
      wr(4'h4, 32'h0);
      wr(4'h8, 32'hC00);
      for (int i = 0; i < 5; i++) wr(4'h0, {14'd0, 2'(i), 4'd0, 12'(12'h100 + i)});
      rd_chk("ovf_status", 4'h8, 32'h0000_0F1F, 32'h0000_0504);
      wr(4'h8, 32'h400);
      rd_chk("ovf_clear", 4'h8, 32'h0000_0400, 32'h0);

      // Push on a tick while full
      wr(4'h4, 32'h1);
      wait_tick_next();
      wr(4'h0, 32'h0003_0ABC);
      chk("full_tick_update", dac_update, 1'b1);
      rd_chk("full_tick_status", 4'h8, 32'h0000_051F, 32'h0000_0104);

      // Flush on a tick with two entries queued
      for (int i = 0; i < 40 && q.size() != 2; i++) idle();
      chk("level_two", q.size(), 2);
      wait_tick_next();
      wr(4'h4, 32'h3);
      chk("flush_noupd", dac_update, 1'b0);
      rd_chk("flush_level", 4'h8, 32'h0000_021F, 32'h0000_0200);

      // Underrun on an empty queue with DIV=1
      wr(4'h4, 32'h2);
      wr(4'h8, 32'hC00);
      wr(4'hC, 32'd1);
      wr(4'h4, 32'h1);
      idle();
      idle();
      rd_chk("underrun", 4'h8, 32'h0000_0800, 32'h0000_0800);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         d = $urandom;
         case (r)
            0, 1, 2: wr(4'h0, d);
            3: wr(4'h4, {29'd0, d[2], ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) != 0)});
            4: wr(4'h8, d);
            5: wr(4'hC, 32'($urandom_range(0, 3)));
            6, 7: step(1'b1, 1'b0, 4'($urandom_range(0, 15)), 32'h0);
            default: idle();
         endcase
      end

      // Reset in the middle of RUN
      wr(4'hC, 32'd1);
      wr(4'h0, 32'h0001_0123);
      wr(4'h0, 32'h0002_0456);
      wr(4'h4, 32'h5);
      idle();
      @(negedge clk);
      bus_valid = 1'b0; bus_we = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_ch0", dac_ch0, 12'h000);
      chk("mid_rst_ch1", dac_ch1, 12'h000);
      chk("mid_rst_ch2", dac_ch2, 12'h000);
      chk("mid_rst_ch3", dac_ch3, 12'h000);
      chk("mid_rst_update", dac_update, 1'b0);
      chk("mid_rst_chan", dac_chan, 2'd0);
      chk("mid_rst_irq", dac_irq, 1'b0);
      @(posedge clk);
      #1;
      chk("mid_rst_hold_update", dac_update, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      rd_chk("post_rst_div", 4'hC, 32'hFFFF_FFFF, 32'h0000_00FF);
      rd_chk("post_rst_status", 4'h8, 32'hFFFF_FFFF, 32'h0000_0200);
      rd_chk("post_rst_ctrl", 4'h4, 32'hFFFF_FFFF, 32'h0);
      for (int i = 0; i < 6; i++) idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
